// File: rtl/demux2_stream.sv
// demux2_stream: routes one input stream to one of two output streams.
// Each output has its own 2-entry {last, data} FIFO, so a stalled output
// never blocks beats routed to the other one.
// Build option DEMUX2_PKT_LOCK_EN: when defined, the select seen on the first
// beat of a multi-beat packet is latched and held until the beat carrying
// I_LAST, so a whole packet always lands on one output. When undefined,
// every beat is routed by the current S and I_LAST is only forwarded.
module demux2_stream #(
   parameter int C_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               S,
   input  logic [C_WIDTH-1:0] I_DATA,
   input  logic               I_VALID,
   input  logic               I_LAST,
   output logic               I_READY,
   output logic [C_WIDTH-1:0] O0_DATA,
   output logic               O0_VALID,
   output logic               O0_LAST,
   input  logic               O0_READY,
   output logic [C_WIDTH-1:0] O1_DATA,
   output logic               O1_VALID,
   output logic               O1_LAST,
   input  logic               O1_READY
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                  state;
   logic                    lock_sel;
   logic                    route;
   logic                    hs_in;
   logic [1:0]              o_ready;
   logic [1:0]              full;
   logic [1:0]              nonempty;
   logic [1:0][C_WIDTH:0]   head;

   // Route follows the latched select only while a packet is in flight.
   assign route   = (state == BUSY) ? lock_sel : S;

   // Ready looks only at the routed FIFO's occupancy, never at the
   // downstream ready, so there is no combinational ready path through us.
   assign I_READY = ~full[route];
   assign hs_in   = I_VALID & I_READY;
   assign o_ready = {O1_READY, O0_READY};

`ifdef DEMUX2_PKT_LOCK_EN
   state_t state_nxt;

   // State register; the select is captured on the first beat of a
   // multi-beat packet and held for the rest of it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         lock_sel <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && hs_in && !I_LAST)
            lock_sel <= S;
      end
   end

   // Next state: open a packet on a non-last beat, close it on the last.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hs_in && !I_LAST) state_nxt = BUSY;
         BUSY:    if (hs_in &&  I_LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
`else
   // Without packet locking there is nothing to remember between beats.
   assign state    = IDLE;
   assign lock_sel = 1'b0;
`endif

   for (genvar g = 0; g < 2; g++) begin : g_fifo
      logic [1:0]            cnt;
      logic                  rptr;
      logic                  wptr;
      logic [1:0][C_WIDTH:0] mem;
      logic                  push;
      logic                  pop;

      assign push        = hs_in & (route == 1'(g));
      assign pop         = nonempty[g] & o_ready[g];
      assign full[g]     = cnt[1];
      assign nonempty[g] = |cnt;
      assign head[g]     = mem[rptr];

      // Two-entry ring buffer; storage is cleared on reset so the outputs
      // read as zero afterwards. Simultaneous push and pop keep the count.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt  <= 2'd0;
            rptr <= 1'b0;
            wptr <= 1'b0;
            mem  <= '0;
         end else begin
            if (push) begin
               mem[wptr] <= {I_LAST, I_DATA};
               wptr      <= ~wptr;
            end
            if (pop)
               rptr <= ~rptr;
            case ({push, pop})
               2'b10:   cnt <= cnt + 2'd1;
               2'b01:   cnt <= cnt - 2'd1;
               default: cnt <= cnt;
            endcase
         end
      end
   end

   assign O0_VALID = nonempty[0];
   assign O0_DATA  = head[0][C_WIDTH-1:0];
   assign O0_LAST  = head[0][C_WIDTH];
   assign O1_VALID = nonempty[1];
   assign O1_DATA  = head[1][C_WIDTH-1:0];
   assign O1_LAST  = head[1][C_WIDTH];

endmodule
